led_matrix_bcm: RTL and testbench

- Parametrised successor to the single-channel scan driver for the NS train panels.
- Drives NUM_CHANNELS parallel serial data lanes sharing one shift clock, latch, enable and row address.
- Reads a synchronous (1-cycle latency) framebuffer and displays BIT_DEPTH-plane binary-coded modulation with a global brightness scale.
- Shifting of the next plane overlaps display of the current one; adds blanking input and frame-start strobe.

---
 rtl/led_matrix_bcm_pkg.sv | 25 ++
 rtl/led_matrix_bcm_if.sv | 27 ++
 rtl/led_matrix_bcm_timer.sv | 53 +++++
 rtl/led_matrix_bcm.sv | 182 ++++++++++++++++++
 tb/tb_led_matrix_bcm.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_bcm_pkg.sv
// Shared definitions for the led_matrix_bcm panel driver.
// Contents: shift FSM state encoding, panel enable polarity, on-time width helper.
package led_matrix_bcm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_RD  = 3'd1,
        ST_CLK_LO   = 3'd2,
        ST_CLK_HI   = 3'd3,
        ST_ROW_DONE = 3'd4,
        ST_LATCH    = 3'd5
    } state_t;

    // Panel output enable is active low: driving this value keeps the panel dark.
    localparam logic ENABLE_OFF = 1'b1;

    localparam int unsigned BRIGHT_W = 8;

    // Period (BASE_TICKS << plane) times (brightness+1) without truncation.
    function automatic int unsigned on_time_width(input int unsigned bit_depth,
                                                  input int unsigned base_ticks);
        return bit_depth + $clog2(base_ticks) + 9;
    endfunction

endpackage

// File: rtl/led_matrix_bcm_if.sv
// Panel + framebuffer bus of the led_matrix_bcm driver.
// master (driver): data_out, clk_out, latch_out, enable_out, addr_out, fb_addr out; fb_data in.
// slave (panel/framebuffer side): the reverse.
interface led_matrix_bcm_if #(
    parameter int unsigned NUM_CHANNELS   = 1,
    parameter int unsigned BIT_DEPTH      = 8,
    parameter int unsigned ROW_ADDR_WIDTH = 4,
    parameter int unsigned FB_ADDR_WIDTH  = 13
);
    logic [NUM_CHANNELS-1:0]           data_out;
    logic                              clk_out;
    logic                              latch_out;
    logic                              enable_out;
    logic [ROW_ADDR_WIDTH-1:0]         addr_out;
    logic [FB_ADDR_WIDTH-1:0]          fb_addr;
    logic [NUM_CHANNELS*BIT_DEPTH-1:0] fb_data;

    modport master (
        output data_out, clk_out, latch_out, enable_out, addr_out, fb_addr,
        input  fb_data
    );

    modport slave (
        input  data_out, clk_out, latch_out, enable_out, addr_out, fb_addr,
        output fb_data
    );
endinterface

// File: rtl/led_matrix_bcm_timer.sv
// BCM display timer: loads a plane period, counts elapsed cycles, and drives the
// active-low panel enable from the brightness-scaled on-time.
// Ports: clk, reset (async high); i_load, i_plane, i_brightness, i_blank in;
//        o_expired_c (period elapsed, combinational), o_enable_n (registered) out.
module led_matrix_bcm_timer
    import led_matrix_bcm_pkg::*;
#(
    parameter int unsigned BIT_DEPTH  = 8,
    parameter int unsigned BASE_TICKS = 64,
    parameter int unsigned PLANE_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [PLANE_W-1:0]  i_plane,
    input  logic [BRIGHT_W-1:0] i_brightness,
    input  logic                i_blank,
    output logic                o_expired_c,
    output logic                o_enable_n
);
    localparam int unsigned OT_W = on_time_width(BIT_DEPTH, BASE_TICKS);

    logic [OT_W-1:0] r_elapsed;
    logic [OT_W-1:0] r_period;
    logic [OT_W-1:0] r_on_time;
    logic [OT_W-1:0] w_period;
    logic [OT_W-1:0] w_scale;

    assign w_period    = OT_W'(BASE_TICKS) << i_plane;
    assign w_scale     = OT_W'(i_brightness) + OT_W'(1);
    assign o_expired_c = (r_elapsed >= r_period);

    // Counter stops at the period; panel stays dark on load and once on-time is used up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_elapsed  <= '0;
            r_period   <= '0;
            r_on_time  <= '0;
            o_enable_n <= ENABLE_OFF;
        end else if (i_load) begin
            r_elapsed  <= '0;
            r_period   <= w_period;
            r_on_time  <= (w_period * w_scale) >> 8;
            o_enable_n <= ENABLE_OFF;
        end else begin
            if (!o_expired_c) begin
                r_elapsed <= r_elapsed + OT_W'(1);
            end
            o_enable_n <= i_blank | (r_elapsed >= r_on_time);
        end
    end

endmodule

// File: rtl/led_matrix_bcm.sv
// Multi-lane LED matrix scan driver with binary-coded modulation. Shifts the next
// bit plane from a 1-cycle-latency framebuffer while the current plane is displayed.
// Ports: clk, reset (async high); bus (master: panel outputs, fb_addr out, fb_data in);
//        brightness, blank in; frame_start out (pulse on row 0 plane 0 latch).
module led_matrix_bcm
    import led_matrix_bcm_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS   = 1,
    parameter int unsigned BIT_DEPTH      = 8,
    parameter int unsigned DISPLAY_WIDTH  = 384,
    parameter int unsigned ROW_ADDR_WIDTH = 4,
    parameter int unsigned FB_ADDR_WIDTH  = 13,
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned BASE_TICKS     = 64
) (
    input  logic                clk,
    input  logic                reset,
    led_matrix_bcm_if.master    bus,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                blank,
    output logic                frame_start
);
    localparam int unsigned ROWS    = 2 ** ROW_ADDR_WIDTH;
    localparam int unsigned X_W     = $clog2(DISPLAY_WIDTH + 1);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

    state_t                    r_state;
    logic [X_W-1:0]            r_x;
    logic [FB_ADDR_WIDTH-1:0]  r_base;
    logic [ROW_ADDR_WIDTH-1:0] r_row;
    logic [PLANE_W-1:0]        r_plane;
    logic [DIV_W-1:0]          r_div;
    logic [BRIGHT_W-1:0]       r_brightness_q;
    logic [NUM_CHANNELS-1:0]   r_data_out;
    logic                      r_clk_out;
    logic                      r_latch_out;
    logic [ROW_ADDR_WIDTH-1:0] r_addr_out;
    logic [FB_ADDR_WIDTH-1:0]  r_fb_addr;
    logic                      r_frame_start;

    logic                      w_expired;
    logic                      w_enable_n;
    logic                      w_latch_go;
    logic                      w_frame_go;
    logic                      w_last_plane;
    logic                      w_div_done;
    logic [X_W-1:0]            w_x_next;
    logic [FB_ADDR_WIDTH-1:0]  w_next_base;
    logic [BRIGHT_W-1:0]       w_bright_sel;
    logic [BIT_DEPTH-1:0]      w_lane;
    logic [NUM_CHANNELS-1:0]   w_plane_bits;

    assign w_latch_go   = (r_state == ST_ROW_DONE) && w_expired;
    assign w_frame_go   = (r_row == '0) && (r_plane == '0);
    assign w_last_plane = (r_plane == PLANE_W'(BIT_DEPTH - 1));
    assign w_div_done   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_x_next     = r_x + X_W'(1);
    assign w_next_base  = (r_row == ROW_ADDR_WIDTH'(ROWS - 1)) ? '0
                        : r_base + FB_ADDR_WIDTH'(DISPLAY_WIDTH);
    // The frame-start latch displays with the brightness sampled in that same cycle.
    assign w_bright_sel = (w_latch_go && w_frame_go) ? brightness : r_brightness_q;

    // Pick the current plane's bit out of every lane's pixel.
    always_comb begin
        w_lane       = '0;
        w_plane_bits = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_lane          = bus.fb_data[c*BIT_DEPTH +: BIT_DEPTH];
            w_plane_bits[c] = w_lane[r_plane];
        end
    end

    led_matrix_bcm_timer #(
        .BIT_DEPTH  (BIT_DEPTH),
        .BASE_TICKS (BASE_TICKS),
        .PLANE_W    (PLANE_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_latch_go),
        .i_plane      (r_plane),
        .i_brightness (w_bright_sel),
        .i_blank      (blank),
        .o_expired_c  (w_expired),
        .o_enable_n   (w_enable_n)
    );

    // Shift FSM. fb_addr is updated on entry to FETCH so read data lands in WAIT_RD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_FETCH;
            r_x            <= '0;
            r_base         <= '0;
            r_row          <= '0;
            r_plane        <= '0;
            r_div          <= '0;
            r_brightness_q <= 8'hFF;
            r_data_out     <= '0;
            r_clk_out      <= 1'b0;
            r_latch_out    <= 1'b0;
            r_addr_out     <= '0;
            r_fb_addr      <= '0;
            r_frame_start  <= 1'b0;
        end else begin
            r_latch_out   <= 1'b0;
            r_frame_start <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    r_data_out <= w_plane_bits;
                    r_clk_out  <= 1'b0;
                    r_div      <= '0;
                    r_state    <= ST_CLK_LO;
                end
                ST_CLK_LO: begin
                    if (w_div_done) begin
                        r_div     <= '0;
                        r_clk_out <= 1'b1;
                        r_state   <= ST_CLK_HI;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_CLK_HI: begin
                    if (w_div_done) begin
                        r_div     <= '0;
                        r_clk_out <= 1'b0;
                        r_x       <= w_x_next;
                        if (w_x_next == X_W'(DISPLAY_WIDTH)) begin
                            r_state <= ST_ROW_DONE;
                        end else begin
                            r_fb_addr <= r_base + FB_ADDR_WIDTH'(w_x_next);
                            r_state   <= ST_FETCH;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_ROW_DONE: begin
                    // Latch only once the previous plane's display time is over (panel dark).
                    if (w_expired) begin
                        r_latch_out   <= 1'b1;
                        r_addr_out    <= r_row;
                        r_frame_start <= w_frame_go;
                        if (w_frame_go) begin
                            r_brightness_q <= brightness;
                        end
                        r_x <= '0;
                        if (w_last_plane) begin
                            r_plane   <= '0;
                            r_row     <= r_row + ROW_ADDR_WIDTH'(1);
                            r_base    <= w_next_base;
                            r_fb_addr <= w_next_base;
                        end else begin
                            r_plane   <= r_plane + PLANE_W'(1);
                            r_fb_addr <= r_base;
                        end
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.clk_out    = r_clk_out;
    assign bus.latch_out  = r_latch_out;
    assign bus.enable_out = w_enable_n;
    assign bus.addr_out   = r_addr_out;
    assign bus.fb_addr    = r_fb_addr;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_led_matrix_bcm.sv
// Directed bench for led_matrix_bcm: a framebuffer model answers reads, expected
// shifts and latch windows are queued up front and popped as the panel outputs them.
module tb_led_matrix_bcm;
    localparam int unsigned NC  = 2;
    localparam int unsigned BD  = 2;
    localparam int unsigned DW  = 4;
    localparam int unsigned RAW = 1;
    localparam int unsigned FAW = 3;
    localparam int unsigned CD  = 1;
    localparam int unsigned BT  = 16;

    typedef struct packed {
        logic [FAW-1:0] addr;
        logic [NC-1:0]  data;
    } shift_t;

    typedef struct {
        logic           fs;
        logic [RAW-1:0] row;
        int             low;
        int             intv;
    } latch_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] brightness;
    logic       blank;
    logic       frame_start;

    logic [NC*BD-1:0] mem [8];

    shift_t q_shift [$];
    latch_t q_latch [$];

    int   errors     = 0;
    int   checks     = 0;
    int   latch_seen = 0;
    int   cyc_since  = 0;
    int   low_cnt    = 0;
    int   pend_low   = 0;
    int   pend_int   = 0;
    bit   have_pend  = 1'b0;
    logic prev_clk   = 1'b0;

    led_matrix_bcm_if #(
        .NUM_CHANNELS   (NC),
        .BIT_DEPTH      (BD),
        .ROW_ADDR_WIDTH (RAW),
        .FB_ADDR_WIDTH  (FAW)
    ) bus ();

    led_matrix_bcm #(
        .NUM_CHANNELS   (NC),
        .BIT_DEPTH      (BD),
        .DISPLAY_WIDTH  (DW),
        .ROW_ADDR_WIDTH (RAW),
        .FB_ADDR_WIDTH  (FAW),
        .CLK_DIV        (CD),
        .BASE_TICKS     (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .brightness  (brightness),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer, one cycle read latency.
    always @(posedge clk) bus.fb_data <= mem[bus.fb_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_data_out",    32'(bus.data_out),   32'd0);
        check("rst_clk_out",     32'(bus.clk_out),    32'd0);
        check("rst_latch_out",   32'(bus.latch_out),  32'd0);
        check("rst_enable_out",  32'(bus.enable_out), 32'd1);
        check("rst_addr_out",    32'(bus.addr_out),   32'd0);
        check("rst_fb_addr",     32'(bus.fb_addr),    32'd0);
        check("rst_frame_start", 32'(frame_start),    32'd0);
    endtask

    task automatic push_shifts(input int row, input int plane);
        shift_t           s;
        logic [NC*BD-1:0] w;
        for (int x = 0; x < int'(DW); x++) begin
            w      = mem[row*DW + x];
            s.addr = FAW'(row*DW + x);
            for (int c = 0; c < int'(NC); c++) s.data[c] = w[c*BD + plane];
            q_shift.push_back(s);
        end
    endtask

    // One row/plane: its shifts, then its latch and the display window that follows it.
    task automatic push_seg(input int row, input int plane, input int low, input int intv);
        latch_t l;
        push_shifts(row, plane);
        l.fs   = (row == 0) && (plane == 0);
        l.row  = RAW'(row);
        l.low  = low;
        l.intv = intv;
        q_latch.push_back(l);
    endtask

    task automatic step();
        shift_t s;
        latch_t l;
        @(negedge clk);
        cyc_since++;
        if (bus.enable_out === 1'b0) low_cnt++;
        if (bus.clk_out === 1'b1 && prev_clk === 1'b0) begin
            checks++;
            assert (q_shift.size() > 0) else begin
                errors++;
                $error("FAIL shift_extra observed=%0d expected=queued entry", q_shift.size());
            end
            if (q_shift.size() > 0) begin
                s = q_shift.pop_front();
                check("shift_fb_addr", 32'(bus.fb_addr), 32'(s.addr));
                check("shift_data", 32'(bus.data_out), 32'(s.data));
            end
        end
        prev_clk = bus.clk_out;
        if (bus.latch_out === 1'b1) begin
            latch_seen++;
            check("latch_dark", 32'(bus.enable_out), 32'd1);
            checks++;
            assert (q_latch.size() > 0) else begin
                errors++;
                $error("FAIL latch_extra observed=%0d expected=queued entry", q_latch.size());
            end
            if (have_pend) begin
                check("on_cycles", low_cnt, pend_low);
                check("latch_interval", cyc_since, pend_int);
            end
            if (q_latch.size() > 0) begin
                l = q_latch.pop_front();
                check("latch_frame_start", 32'(frame_start), 32'(l.fs));
                check("latch_addr_out", 32'(bus.addr_out), 32'(l.row));
                pend_low  = l.low;
                pend_int  = l.intv;
                have_pend = 1'b1;
            end
            cyc_since = 0;
            low_cnt   = 0;
        end
    endtask

    task automatic run_latches(input int target, input int budget);
        int n = 0;
        while (latch_seen < target && n < budget) begin
            step();
            n++;
        end
        check("latch_count", latch_seen, target);
    endtask

    initial begin
        for (int a = 0; a < 4; a++) mem[a] = 4'b1001;
        mem[4] = 4'b1110;
        mem[5] = 4'b0111;
        mem[6] = 4'b1011;
        mem[7] = 4'b0100;

        reset      = 1'b1;
        brightness = 8'hFF;
        blank      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();

        // Frame 1 and 2 at full brightness (frame 2 plane 1 blanked for 5 cycles),
        // frame 3 at 0x7F, then part of row 1 before a mid-shift reset.
        push_seg(0, 0, 16, 18);
        push_seg(0, 1, 32, 33);
        push_seg(1, 0, 16, 18);
        push_seg(1, 1, 32, 33);
        push_seg(0, 0, 16, 18);
        push_seg(0, 1, 27, 33);
        push_seg(1, 0, 16, 18);
        push_seg(1, 1, 32, 33);
        push_seg(0, 0,  8, 18);
        push_seg(0, 1, 16, 33);
        push_shifts(1, 0);

        reset = 1'b0;
        run_latches(5, 300);
        brightness = 8'h7F;

        run_latches(6, 100);
        repeat (5) step();
        blank = 1'b1;
        repeat (5) begin
            step();
            check("blank_dark", 32'(bus.enable_out), 32'd1);
        end
        blank = 1'b0;

        run_latches(10, 400);
        repeat (6) step();

        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        q_shift.delete();
        q_latch.delete();
        have_pend  = 1'b0;
        latch_seen = 0;
        cyc_since  = 0;
        low_cnt    = 0;
        prev_clk   = bus.clk_out;

        push_seg(0, 0,  8, 18);
        push_seg(0, 1, 16, 33);
        push_seg(1, 0,  8, 18);
        run_latches(3, 300);

        check("latch_queue_drained", q_latch.size(), 0);
        check("shift_queue_drained", q_shift.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
